// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Watches a scanned, multiplexed seven-segment bus and turns it back into a
//   multi-digit hex value. It works as a loopback monitor for the display driver.
//   The last cycle of each digit dwell is decoded into a shadow frame. A frame
//   is complete once every digit position has been committed. The value is
//   published only after STABLE_CNT consecutive identical complete frames.
//
// Ports
//   clk          rising-edge system clock
//   rst          synchronous active-high reset
//   seg_in[6:0]  segment lines, active-high, bit0=a .. bit6=g
//   dig_sel      one-hot digit enable; all-zero is a blanking gap
//   value        published hex value, digit i at value[4i+3:4i]
//   value_valid  one-cycle pulse when value is updated
//   seg_error    one-cycle pulse on an undecodable pattern or a multi-hot select
module seg_scan_decoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          seg_in,
  input  logic [DIGITS-1:0]   dig_sel,
  output logic [4*DIGITS-1:0] value,
  output logic                value_valid,
  output logic                seg_error
);

  localparam int RUN_W = (STABLE_CNT < 1) ? 1 : $clog2(STABLE_CNT + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [RUN_W-1:0]    RUN_MAX   = RUN_W'(STABLE_CNT);
  localparam logic [RUN_W-1:0]    RUN_ZERO  = {RUN_W{1'b0}};
  localparam logic [RUN_W-1:0]    RUN_ONE   = RUN_W'(1);
  localparam logic [DIGITS-1:0]   SEL_ZERO  = {DIGITS{1'b0}};
  localparam logic [DIGITS-1:0]   SEL_ALL   = {DIGITS{1'b1}};
  localparam logic [4*DIGITS-1:0] FRAME_ZERO = {(4*DIGITS){1'b0}};

  // Inverse of the hex-to-segment encoding: {valid, nibble}.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  function automatic logic is_onehot(input logic [DIGITS-1:0] v);
    return (v != SEL_ZERO) && ((v & (v - 1'b1)) == SEL_ZERO);
  endfunction

  // Only meaningful for a one-hot input; OR-ing the set positions keeps it mux-free.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [DIGITS-1:0] v);
    logic [IDX_W-1:0] r;
    r = {IDX_W{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      r = r | ({IDX_W{v[i]}} & IDX_W'(i));
    end
    return r;
  endfunction

  logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic [6:0]          seg_q, seg_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [4*DIGITS-1:0] prev_frame_q, prev_frame_d;
  logic                published_q, published_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic                value_valid_q, value_valid_d;
  logic                seg_error_q, seg_error_d;

  logic [4:0]          decoded_s;
  logic [IDX_W-1:0]    idx_s;
  logic [DIGITS-1:0]   seen_next_s;

  assign decoded_s   = seg_decode(seg_q);
  assign idx_s       = onehot_idx(dig_sel_q);
  assign seen_next_s = seen_q | dig_sel_q;

  // Dwell-end commit, frame assembly, stability run and publish decision.
  always_comb begin
    dig_sel_d     = dig_sel;
    seg_d         = seg_in;
    shadow_d      = shadow_q;
    seen_d        = seen_q;
    run_d         = run_q;
    prev_frame_d  = prev_frame_q;
    published_d   = published_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    seg_error_d   = 1'b0;
    if (dig_sel != dig_sel_q) begin
      if (dig_sel_q == SEL_ZERO) begin
        // End of a blanking gap: the segment lines carry nothing meaningful.
        seen_d = seen_q;
      end else if (!is_onehot(dig_sel_q)) begin
        seg_error_d = 1'b1;
        shadow_d    = FRAME_ZERO;
        seen_d      = SEL_ZERO;
        run_d       = RUN_ZERO;
      end else if (!decoded_s[4]) begin
        // Shadow is kept; clearing seen alone discards the frame.
        seg_error_d = 1'b1;
        seen_d      = SEL_ZERO;
        run_d       = RUN_ZERO;
      end else begin
        shadow_d[int'(idx_s)*4 +: 4] = decoded_s[3:0];
        if (seen_next_s == SEL_ALL) begin
          seen_d = SEL_ZERO;
          if (shadow_d == prev_frame_q) begin
            run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 1'b1;
          end else begin
            run_d = RUN_ONE;
          end
          prev_frame_d = shadow_d;
          if ((run_d >= RUN_MAX) && (!published_q || (shadow_d != value_q))) begin
            value_d       = shadow_d;
            value_valid_d = 1'b1;
            published_d   = 1'b1;
          end else begin
            value_d = value_q;
          end
        end else begin
          seen_d = seen_next_s;
        end
      end
    end else begin
      seen_d = seen_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_sel_q     <= SEL_ZERO;
      seg_q         <= 7'h00;
      shadow_q      <= FRAME_ZERO;
      seen_q        <= SEL_ZERO;
      run_q         <= RUN_ZERO;
      prev_frame_q  <= FRAME_ZERO;
      published_q   <= 1'b0;
      value_q       <= FRAME_ZERO;
      value_valid_q <= 1'b0;
      seg_error_q   <= 1'b0;
    end else begin
      dig_sel_q     <= dig_sel_d;
      seg_q         <= seg_d;
      shadow_q      <= shadow_d;
      seen_q        <= seen_d;
      run_q         <= run_d;
      prev_frame_q  <= prev_frame_d;
      published_q   <= published_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      seg_error_q   <= seg_error_d;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign seg_error   = seg_error_q;

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Decodes a multiplexed, scanned seven-segment display bus back into hex digits. It samples segment lines plus one-hot digit selects, inverts the hex-to-segment encoding per digit, and checks frame consistency. It publishes a stable multi-digit value only after several consecutive identical scan frames. It sits on the display side of the lab designs as a loopback and self-check monitor for the display driver path.

## Interface
- DIGITS, 4, number of scanned digit positions (one-hot select width).
- STABLE_CNT, 3, consecutive identical good frames required before publishing (≥1).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- seg_in  input  7  segment lines, active-high, bit0=a … bit6=g.
- dig_sel  input  DIGITS  digit enable, active-high; bit i selects digit i; all-zero = blanking gap.
- value  output  4*DIGITS  published hex value; digit i at value[4i+3:4i].
- value_valid  output  1  one-cycle pulse when value is updated.
- seg_error  output  1  one-cycle pulse on invalid pattern or multi-hot select.

## Operation
- Decode table (pattern→nibble, hex pattern g..a): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F. Any other pattern is invalid.
- Registers dig_sel_q and seg_q hold the previous cycle's dig_sel and seg_in.
- Dwell end: dig_sel ≠ dig_sel_q. If dig_sel_q is one-hot, commit decode(seg_q) into shadow[idx(dig_sel_q)] and set seen[idx]. The last cycle of a dwell is the sampled one.
- If dig_sel_q is zero at dwell end (gap), nothing is committed and seg_in is ignored.
- If dig_sel_q is multi-hot at dwell end: seg_error pulse, shadow and seen cleared, and run cleared.
- Invalid pattern at commit: seg_error pulse, frame discarded (seen cleared), and run cleared.
- The same digit committed twice in one frame is overwritten; the later commit wins.
- Frame complete is the commit that makes seen all-ones. seen clears at that same edge.
- Run counter (saturating at STABLE_CNT) at frame complete:
  - If frame == prev_frame, run+1.
  - Otherwise run=1.
  - prev_frame ← frame.
- Publish when run (after update) ≥ STABLE_CNT and (nothing published since reset, or frame ≠ value). Publishing sets value ← frame and pulses value_valid.
- Identical frames after a publish do not re-pulse.
- dig_sel held constant indefinitely: no commits and no outputs.

## Timing
- Reset values:
  - value=0, value_valid=0, seg_error=0.
  - dig_sel_q=0, seg_q=0, seen=0, run=0, prev_frame=0.
  - published flag=0.
- Reset mid-frame discards the partial frame and the run count.
- Latency: the transition appears on dig_sel in cycle T; the commit occurs at the end of T. value, value_valid, and seg_error reflect it in cycle T+1.
- Minimum dwell is 1 cycle. Back-to-back dwell ends on consecutive cycles are all committed.
- seg_error and value_valid cannot both be high in one cycle: an erroring commit never completes a frame.
- Throughput: one commit per cycle. No backpressure.

## Test plan
- Reset, then 3 frames scanning digits 0..3 with 06,5B,4F,66 (dwell 4, no gaps). Required: no pulse after frames 1–2; a single value_valid 1 cycle after the digit-3 dwell end of frame 3; value=16'h4321.
- Continue with a 4th identical frame, then 3 frames with digit 0 = 7F. Required: no pulse on frame 4; a pulse after the 3rd changed frame with value=16'h4328.
- Frame with pattern 00 on digit 2. Required: seg_error high exactly 1 cycle after that dwell ends; value unchanged; 3 further good frames are needed before the next publish.
- dig_sel=4'b0011 for 1 cycle mid-frame. Required: seg_error pulse; frame discarded; a subsequent clean 3-frame sequence publishes normally.
- Assert rst after 2 digits of a frame. Required: all outputs 0 the next cycle; the 3 complete frames that follow publish the correct value.
- Gaps (dig_sel=0, seg_in=7F) of 2 cycles between every digit, plus 1-cycle dwells, encoding 16'hFA0b. Required: no seg_error; value=16'hFA0b after frame 3.
